// File: rtl/es7243e_reg_readback.sv
// I2C random-read initiator for ES7243E register readback: S, dev-W, reg, Sr, dev-R, data, NACK, P.
// Optional `I2C_NACK_ABORT_EN: a NACK on any address/register byte jumps straight to STOP.
module es7243e_reg_readback #(
    parameter logic [6:0]  DEV_ADDR = 7'h10,
    parameter int unsigned QDIV     = 30
) (
    input  logic       clk_12M,
    input  logic       rstn,
    input  logic       req,
    input  logic [7:0] reg_addr,
    output logic       busy,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       ack_err,
    output logic       i2c_sclk,
    inout  wire        i2c_sdat
);

`ifdef I2C_NACK_ABORT_EN
    localparam bit ABORT = 1'b1;
`else
    localparam bit ABORT = 1'b0;
`endif

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_WADDR, S_ACK1, S_WREG, S_ACK2, S_RSTART,
        S_RADDR, S_ACK3, S_RDATA, S_MNACK, S_STOP, S_DONE
    } state_t;

    state_t      state_q;
    logic [15:0] qcnt_q;
    logic [1:0]  ph_q;
    logic [2:0]  bit_q;
    logic [7:0]  tx_q;
    logic [7:0]  rx_q;
    logic [7:0]  addr_q;
    logic        busy_q;
    logic [7:0]  rd_data_q;
    logic        rd_valid_q;
    logic        ack_err_q;
    logic        scl_q;
    logic        sda_low_q;
    logic        sda_low_dly_q;
    logic        scl_d;
    logic        sda_low_d;
    logic        tick;
    logic        in_byte;

    assign tick    = (state_q != S_IDLE) && (qcnt_q == 16'(QDIV - 1));
    assign in_byte = state_q inside {S_WADDR, S_WREG, S_RADDR, S_RDATA};

    always_comb begin
        scl_d     = 1'b1;
        sda_low_d = 1'b0;
        case (state_q)
            // Sr drops SCL in q0 so the slave can let go of its ACK before SDA is released high.
            S_START, S_RSTART: begin
                scl_d     = (state_q == S_START) || (ph_q != 2'd0);
                sda_low_d = ph_q[1];
            end
            S_WADDR, S_WREG, S_RADDR: begin
                scl_d     = ph_q[1];
                sda_low_d = !tx_q[7];
            end
            S_ACK1, S_ACK2, S_ACK3, S_RDATA, S_MNACK: scl_d = ph_q[1];
            S_STOP: begin
                scl_d     = ph_q[1];
                sda_low_d = (ph_q != 2'd3);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_12M or negedge rstn) begin
        if (!rstn) begin
            state_q       <= S_IDLE;
            qcnt_q        <= '0;
            ph_q          <= '0;
            bit_q         <= '0;
            tx_q          <= '0;
            rx_q          <= '0;
            addr_q        <= '0;
            busy_q        <= 1'b0;
            rd_data_q     <= '0;
            rd_valid_q    <= 1'b0;
            ack_err_q     <= 1'b0;
            scl_q         <= 1'b1;
            sda_low_q     <= 1'b0;
            sda_low_dly_q <= 1'b0;
        end else begin
            rd_valid_q    <= 1'b0;
            busy_q        <= (state_q != S_IDLE) || req;
            scl_q         <= scl_d;
            sda_low_q     <= sda_low_d;
            // SDA trails SCL by one extra cycle so data never moves while SCL is still high.
            sda_low_dly_q <= sda_low_q;
            if (state_q == S_IDLE) begin
                qcnt_q <= '0;
                ph_q   <= '0;
                bit_q  <= '0;
                if (req) begin
                    state_q   <= S_START;
                    addr_q    <= reg_addr;
                    ack_err_q <= 1'b0;
                end
            end else if (state_q == S_DONE) begin
                state_q <= S_IDLE;
                qcnt_q  <= '0;
                if (!ack_err_q) begin
                    rd_data_q  <= rx_q;
                    rd_valid_q <= 1'b1;
                end
            end else begin
                qcnt_q <= tick ? '0 : qcnt_q + 16'd1;
                if (tick) begin
                    ph_q <= ph_q + 2'd1;
                    if (ph_q == 2'd2) begin
                        if ((state_q inside {S_ACK1, S_ACK2, S_ACK3}) && i2c_sdat)
                            ack_err_q <= 1'b1;
                        if (state_q == S_RDATA)
                            rx_q <= {rx_q[6:0], i2c_sdat};
                    end
                    if (ph_q == 2'd3) begin
                        bit_q <= in_byte ? bit_q + 3'd1 : '0;
                        tx_q  <= {tx_q[6:0], 1'b0};
                        case (state_q)
                            S_START: begin
                                state_q <= S_WADDR;
                                tx_q    <= {DEV_ADDR, 1'b0};
                            end
                            S_WADDR: if (bit_q == 3'd7) state_q <= S_ACK1;
                            S_ACK1: begin
                                if (ABORT && ack_err_q) state_q <= S_STOP;
                                else begin
                                    state_q <= S_WREG;
                                    tx_q    <= addr_q;
                                end
                            end
                            S_WREG: if (bit_q == 3'd7) state_q <= S_ACK2;
                            S_ACK2: state_q <= (ABORT && ack_err_q) ? S_STOP : S_RSTART;
                            S_RSTART: begin
                                state_q <= S_RADDR;
                                tx_q    <= {DEV_ADDR, 1'b1};
                            end
                            S_RADDR: if (bit_q == 3'd7) state_q <= S_ACK3;
                            S_ACK3:  state_q <= (ABORT && ack_err_q) ? S_STOP : S_RDATA;
                            S_RDATA: if (bit_q == 3'd7) state_q <= S_MNACK;
                            S_MNACK: state_q <= S_STOP;
                            S_STOP:  state_q <= S_DONE;
                            default: state_q <= S_IDLE;
                        endcase
                    end
                end
            end
        end
    end

    assign busy     = busy_q;
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign ack_err  = ack_err_q;
    assign i2c_sclk = scl_q;
    assign i2c_sdat = sda_low_dly_q ? 1'b0 : 1'bz;

endmodule
